apo_node_interface_9_nodes: RTL
===============================

Name: apo_node_interface_9_nodes

Overview:
- Node-side network interface for one node of the circulant C(9; 2, 3) router fabric.
- Transmit side: accepts destination requests from the local compute node, queues them, and drives the router's free (compute-node) input with well-formed injection packets.
- Receive side: watches the router's delivery outputs, counts arrivals addressed to this node, and hands them back through a valid/ready handshake.
- One instance sits between each compute node and its apo_router_9_nodes.

Parameters:
- NODE_COUNT, 9, number of routers in the circulant.
- K, 4, width of a node number.
- N2, 9, packet width: bit 8 is the valid/emulation flag, bits 7:0 are payload.
- FIFO_DEPTH, 4, injection queue depth (power of two).
- MIN_GAP, 2, idle cycles forced on inj_pkt after each injection (range 1..15).
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- node_id  in  K  this node's number; static after reset.
- req_valid  in  1  compute node offers a destination.
- req_dest  in  K  destination node number.
- req_ready  out  1  interface can accept a request.
- inj_pkt  out  N2  to the router's free input.
- rtr_out_data  in  1  router delivery strobe.
- rtr_out_data_buffer  in  N2  router delivery payload.
- rx_valid  out  1  at least one delivery is pending.
- rx_ready  in  1  compute node consumes one delivery.
- rx_overflow  out  1  sticky: a delivery was lost.
- err_bad_dest  out  1  one-cycle pulse: a request was dropped.
- busy  out  1  FIFO not empty or FSM not IDLE.
- tx_count  out  CNT_W  packets injected, saturating.
- rx_count  out  CNT_W  deliveries seen, saturating.

Behaviour:
- Reset state (asynchronous, takes effect immediately):
  - All outputs 0 except req_ready=1.
  - FIFO empty, FSM in IDLE, gap counter 0, pending count 0.
- Request accept:
  - A request is taken when req_valid && req_ready at a posedge.
  - req_ready = !fifo_full; combinational from FIFO state only, never from req_valid.
- Bad destination:
  - req_dest >= NODE_COUNT is still accepted (handshake completes) but is not pushed.
  - err_bad_dest is high for exactly the cycle after acceptance.
- Self destination: req_dest == node_id is legal and is injected normally.
- Injection packet format: {1'b1, 4'b0000, dest[3:0]}. Bits 7:4 are always zero.
- FSM IDLE:
  - inj_pkt = 0.
  - If the FIFO is not empty, go to INJECT.
- FSM INJECT (exactly one cycle):
  - inj_pkt = packet built from the FIFO head; pop the head; tx_count++.
  - Go to GAP with the gap counter loaded to MIN_GAP-1.
- FSM GAP:
  - inj_pkt = 0; decrement the gap counter.
  - At 0, go to IDLE.
- Injection latency and spacing:
  - A request accepted at edge t into an empty, IDLE interface drives inj_pkt during cycle t+2: IDLE sees the non-empty FIFO after edge t+1, enters INJECT at edge t+2.
  - Back-to-back injections are spaced exactly MIN_GAP+2 cycles apart (INJECT, GAP, IDLE).
- FIFO concurrency:
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - A push while full cannot occur because req_ready=0.
- Delivery event:
  - Defined as rtr_out_data==1 && rtr_out_data_buffer[7:0]==0 at a posedge.
  - rtr_out_data==1 with a non-zero payload is an in-transit indication and is ignored.
  - Delivery of a self-addressed packet (buffer[7:0]==node_id) also counts as a delivery event, but only when node_id==0.
- Pending count (4 bits):
  - A delivery event increments it; rx_valid && rx_ready decrements it.
  - Both in the same cycle: unchanged.
  - A delivery at 15 without a concurrent pop: count stays 15 and rx_overflow is set; it clears only on reset.
- rx_valid = (pending != 0), registered.
- Counters: tx_count and rx_count saturate at 2^CNT_W-1 and never wrap.
- busy is registered and reflects state after each edge.
- Reset mid-injection: inj_pkt drops to 0 asynchronously and the queued requests are lost.

Decomposition:
- Shared package apo_pkg holds:
  - constants NODE_COUNT, K, N2;
  - the packet valid-bit index (8);
  - the steps field offsets (7:4 = large generator, 3:0 = small generator);
  - a function make_inject_pkt(dest) used by both this block and the testbench.
- One sub-module, apo_sync_fifo (parameters WIDTH=K, DEPTH=FIFO_DEPTH), provides full/empty/count with registered outputs.
- The FSM, gap counter, pending counter and statistics counters stay in the top level.

Test Plan:
- Reset; node_id=3; one request dest=7 at edge 1 → inj_pkt=9'b1_0000_0111 for exactly one cycle at cycle 3, 0 otherwise; tx_count=1.
- Six back-to-back requests with MIN_GAP=2 → req_ready deasserts when the FIFO holds 4. Injections land at cycles 3, 7, 11, 15, 19, 23 (4 cycles apart); all six are injected in order; busy falls after the last GAP.
- Request dest=9 and dest=15 → accepted, err_bad_dest pulses once per request, no injection, tx_count unchanged.
- rtr_out_data=1 with buffer=9'h000 for 3 cycles, rx_ready=0 → rx_valid=1, rx_count=3. Then one cycle of rx_ready=1 coinciding with another delivery → pending stays 3.
- rtr_out_data=1 with buffer=9'h013 → ignored; rx_count unchanged, rx_valid stays 0.
- 16 deliveries with rx_ready=0 → rx_overflow=1 after the 16th; then assert rst_n=0 mid-GAP → all outputs return to reset values immediately.

Source files
------------

// File: rtl/apo_pkg.sv
// Shared constants and packet helpers for the C(9; 2, 3) router fabric.
// Used by the node interface and its testbench.
package apo_pkg;

    localparam int NODE_COUNT = 9;
    localparam int K          = 4;
    localparam int N2         = 9;
    localparam int VALID_BIT  = 8;
    localparam int LG_HI      = 7;
    localparam int LG_LO      = 4;
    localparam int SM_HI      = 3;
    localparam int SM_LO      = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INJECT,
        ST_GAP
    } inj_state_t;

    function automatic logic [N2-1:0] make_inject_pkt(input logic [K-1:0] dest);
        logic [N2-1:0] p;
        p                = '0;
        p[VALID_BIT]     = 1'b1;
        p[LG_HI:LG_LO]   = '0;
        p[SM_HI:SM_LO]   = dest;
        return p;
    endfunction

endpackage

// File: rtl/apo_sync_fifo.sv
// Small synchronous FIFO with registered full/empty/count.
// Push while full and pop while empty are ignored.
module apo_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        cnt_nxt = count;
        if (do_push && !do_pop)
            cnt_nxt = count + CW'(1);
        else if (do_pop && !do_push)
            cnt_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= cnt_nxt;
            full  <= (cnt_nxt == CW'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/apo_node_interface_9_nodes.sv
// Node-side network interface: queues destination requests into injection
// packets for the router and counts/hands back deliveries to this node.
module apo_node_interface_9_nodes
    import apo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [K-1:0]     node_id,
    input  logic             req_valid,
    input  logic [K-1:0]     req_dest,
    output logic             req_ready,
    output logic [N2-1:0]    inj_pkt,
    input  logic             rtr_out_data,
    input  logic [N2-1:0]    rtr_out_data_buffer,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overflow,
    output logic             err_bad_dest,
    output logic             busy,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    inj_state_t    state;
    inj_state_t    state_nxt;
    logic [3:0]    gap;
    logic [3:0]    pending;
    logic [3:0]    pend_nxt;
    logic          ovf_set;
    logic          avail;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] fifo_lvl_nxt;
    logic [K-1:0]  head;
    logic          accept;
    logic          bad;
    logic          push;
    logic          pop;
    logic          deliver;
    logic          rx_pop;
    logic          unused_valid_bit;

    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign bad       = req_dest >= K'(NODE_COUNT);
    assign push      = accept && !bad;
    assign pop       = (state == ST_INJECT);
    assign rx_pop    = rx_valid && rx_ready;

    // Self-addressed arrivals only count for node 0.
    assign deliver = rtr_out_data &&
        (rtr_out_data_buffer[VALID_BIT-1:0] == '0 ||
         (node_id == '0 &&
          rtr_out_data_buffer[VALID_BIT-1:0] == {4'b0000, node_id}));

    assign unused_valid_bit = rtr_out_data_buffer[VALID_BIT];

    apo_sync_fifo #(
        .WIDTH (K),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (req_dest),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (avail) state_nxt = ST_INJECT;
            ST_INJECT: state_nxt = ST_GAP;
            ST_GAP:    if (gap == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        inj_pkt = '0;
        if (state == ST_INJECT)
            inj_pkt = make_inject_pkt(head);
    end

    always_comb begin
        fifo_lvl_nxt = fifo_cnt;
        if (push && !pop)
            fifo_lvl_nxt = fifo_cnt + CW'(1);
        else if (pop && !push)
            fifo_lvl_nxt = fifo_cnt - CW'(1);
    end

    always_comb begin
        pend_nxt = pending;
        ovf_set  = 1'b0;
        if (deliver && !rx_pop) begin
            if (pending == 4'hf)
                ovf_set = 1'b1;
            else
                pend_nxt = pending + 4'd1;
        end else if (rx_pop && !deliver) begin
            pend_nxt = pending - 4'd1;
        end
    end

    // avail lags the FIFO by one cycle, giving the two-cycle request latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap          <= '0;
            avail        <= 1'b0;
            pending      <= '0;
            rx_valid     <= 1'b0;
            rx_overflow  <= 1'b0;
            err_bad_dest <= 1'b0;
            busy         <= 1'b0;
            tx_count     <= '0;
            rx_count     <= '0;
        end else begin
            if (state == ST_INJECT)
                gap <= 4'(MIN_GAP - 1);
            else if (state == ST_GAP && gap != '0)
                gap <= gap - 4'd1;
            avail        <= !fifo_empty;
            pending      <= pend_nxt;
            rx_valid     <= (pend_nxt != '0);
            rx_overflow  <= rx_overflow || ovf_set;
            err_bad_dest <= accept && bad;
            busy         <= (state_nxt != ST_IDLE) || (fifo_lvl_nxt != '0);
            if (pop && tx_count != '1)
                tx_count <= tx_count + CNT_W'(1);
            if (deliver && rx_count != '1)
                rx_count <= rx_count + CNT_W'(1);
        end
    end

endmodule
